// File: rtl/ex_mem_stage_receiver_pkg.sv
// Common types and constants for the EX->MEM stage receiver.
// Build option: EX_MEM_OVERFLOW_TRAP_EN (see ex_mem_stage_receiver.sv).
package ex_mem_stage_receiver_pkg;

    localparam int EXM_DEPTH_DEF = 2;
    localparam int EXM_DATA_W    = 32;
    localparam int FLAG_OVF      = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_COMP     = 0;

    // EX control word
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] alu_op;
    } control_type;

    // Complete EX output bundle as held in one buffer entry
    typedef struct packed {
        control_type            ctrl;
        logic [EXM_DATA_W-1:0]  alu;
        logic [EXM_DATA_W-1:0]  wdata;
        logic                   ovf;
        logic                   zero;
        logic                   comp;
        logic [EXM_DATA_W-1:0]  pc;
    } ex_bundle_t;

    // Gather the stored flags into the {overflow, zero, comp} output order
    function automatic logic [2:0] pack_flags(input ex_bundle_t b);
        logic [2:0] f;
        f            = '0;
        f[FLAG_OVF]  = b.ovf;
        f[FLAG_ZERO] = b.zero;
        f[FLAG_COMP] = b.comp;
        return f;
    endfunction

endpackage

// File: rtl/ex_mem_fifo.sv
// Generic DEPTH-entry FIFO of ex_bundle_t with push, pop, flush and occupancy.
module ex_mem_fifo
    import ex_mem_stage_receiver_pkg::*;
#(
    parameter int DEPTH = EXM_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  ex_bundle_t               i_wdata,
    output ex_bundle_t               o_head,
    output ex_bundle_t               o_newest,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ex_bundle_t      r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_newest_idx;

    // Entry storage; cleared on reset so empty-state outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    // Head and newest-entry taps straight from storage
    always_comb begin
        w_newest_idx = r_wptr - PW'(1);
        o_head       = r_mem[r_rptr];
        o_newest     = r_mem[w_newest_idx];
        o_count      = r_count;
    end

endmodule

// File: rtl/ex_mem_stage_receiver.sv
// EX->MEM stage receiver: elastic buffer with valid/ready, flush, forwarding tap.
// Build option: EX_MEM_OVERFLOW_TRAP_EN drops overflowing bundles and pulses trap.
module ex_mem_stage_receiver
    import ex_mem_stage_receiver_pkg::*;
#(
    parameter int DEPTH  = EXM_DEPTH_DEF,
    parameter int DATA_W = EXM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  control_type              control_out,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic [DATA_W-1:0]        memory_data,
    input  logic                     overflow_flag,
    input  logic                     zero_flag,
    input  logic                     compflg_out,
    input  logic [DATA_W-1:0]        program_counter,
    input  logic                     flush,
    input  logic                     mem_ready,
    output logic                     mem_valid,
    output control_type              mem_ctrl,
    output logic [DATA_W-1:0]        mem_alu,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W-1:0]        mem_pc,
    output logic [2:0]               mem_flags,
    output logic                     fwd_valid,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     trap
);

    localparam int CW = $clog2(DEPTH) + 1;

    ex_bundle_t      w_in;
    ex_bundle_t      w_head;
    ex_bundle_t      w_newest;
    logic [CW-1:0]   w_count;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;

    // Handshake glue; readiness derives only from registered occupancy
    always_comb begin
        w_in.ctrl  = control_out;
        w_in.alu   = alu_data;
        w_in.wdata = memory_data;
        w_in.ovf   = overflow_flag;
        w_in.zero  = zero_flag;
        w_in.comp  = compflg_out;
        w_in.pc    = program_counter;
        ex_ready   = (w_count != CW'(DEPTH));
        mem_valid  = (w_count != '0);
        fwd_valid  = (w_count != '0);
        w_accept   = ex_valid && ex_ready && !flush;
        w_pop      = mem_valid && mem_ready && !flush;
`ifdef EX_MEM_OVERFLOW_TRAP_EN
        w_push     = w_accept && !overflow_flag;
`else
        w_push     = w_accept;
`endif
    end

    ex_mem_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (flush),
        .i_wdata  (w_in),
        .o_head   (w_head),
        .o_newest (w_newest),
        .o_count  (w_count)
    );

    // Head fields and forwarding tap presented from buffer storage
    always_comb begin
        mem_ctrl  = w_head.ctrl;
        mem_alu   = w_head.alu;
        mem_wdata = w_head.wdata;
        mem_pc    = w_head.pc;
        mem_flags = pack_flags(w_head);
        fwd_data  = w_newest.alu;
        count     = w_count;
    end

`ifdef EX_MEM_OVERFLOW_TRAP_EN
    logic r_trap;

    // One-cycle trap pulse after an accepted overflowing bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trap <= 1'b0;
        else        r_trap <= w_accept && overflow_flag;
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_receiver.sv
// Randomized + directed bench for ex_mem_stage_receiver against a queue model.
module tb_ex_mem_stage_receiver;
    import ex_mem_stage_receiver_pkg::*;

    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    control_type       control_out;
    logic [31:0]       alu_data;
    logic [31:0]       memory_data;
    logic              overflow_flag;
    logic              zero_flag;
    logic              compflg_out;
    logic [31:0]       program_counter;
    logic              flush;
    logic              mem_ready;
    logic              mem_valid;
    control_type       mem_ctrl;
    logic [31:0]       mem_alu;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_pc;
    logic [2:0]        mem_flags;
    logic              fwd_valid;
    logic [31:0]       fwd_data;
    logic [1:0]        count;
    logic              trap;
    logic [7:0]        ctrl_bits;

    assign ctrl_bits = mem_ctrl;

    ex_mem_stage_receiver #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .control_out     (control_out),
        .alu_data        (alu_data),
        .memory_data     (memory_data),
        .overflow_flag   (overflow_flag),
        .zero_flag       (zero_flag),
        .compflg_out     (compflg_out),
        .program_counter (program_counter),
        .flush           (flush),
        .mem_ready       (mem_ready),
        .mem_valid       (mem_valid),
        .mem_ctrl        (mem_ctrl),
        .mem_alu         (mem_alu),
        .mem_wdata       (mem_wdata),
        .mem_pc          (mem_pc),
        .mem_flags       (mem_flags),
        .fwd_valid       (fwd_valid),
        .fwd_data        (fwd_data),
        .count           (count),
        .trap            (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [2:0]  fl;
        logic [7:0]  ctrl;
    } ent_t;

    ent_t q[$];
    logic trap_exp;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count",     64'(count),     64'(q.size()));
        chk("ex_ready",  64'(ex_ready),  64'(q.size() < DEPTH));
        chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        chk("fwd_valid", 64'(fwd_valid), 64'(q.size() != 0));
        chk("trap",      64'(trap),      64'(trap_exp));
        if (q.size() != 0) begin
            chk("mem_alu",   64'(mem_alu),   64'(q[0].alu));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].wd));
            chk("mem_pc",    64'(mem_pc),    64'(q[0].pc));
            chk("mem_flags", 64'(mem_flags), 64'(q[0].fl));
            chk("mem_ctrl",  64'(ctrl_bits), 64'(q[0].ctrl));
            chk("fwd_data",  64'(fwd_data),  64'(q[q.size()-1].alu));
        end
    endtask

    // One cycle: check current outputs, drive inputs, advance model across the edge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [2:0] fl, input logic [7:0] c,
                        input logic fsh, input logic mr);
        bit   acc, pp;
        ent_t e;
        check_outputs();
        ex_valid        = v;
        alu_data        = a;
        memory_data     = wd;
        program_counter = pc;
        overflow_flag   = fl[2];
        zero_flag       = fl[1];
        compflg_out     = fl[0];
        control_out     = c;
        flush           = fsh;
        mem_ready       = mr;
        acc = v && (q.size() < DEPTH) && !fsh;
        pp  = (q.size() != 0) && mr && !fsh;
        e.alu = a; e.wd = wd; e.pc = pc; e.fl = fl; e.ctrl = c;
        @(posedge clk);
        trap_exp = 1'b0;
        if (fsh) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
`ifdef EX_MEM_OVERFLOW_TRAP_EN
                if (fl[2]) trap_exp = 1'b1;
                else       q.push_back(e);
`else
                q.push_back(e);
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic mr);
        step(1'b0, '0, '0, '0, 3'b000, 8'h00, 1'b0, mr);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] pc, input logic [2:0] fl,
                        input logic mr);
        step(1'b1, a, ~a, pc, fl, a[7:0], 1'b0, mr);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b1; alu_data = 32'hDEAD_BEEF; memory_data = '0;
        program_counter = '0; overflow_flag = 1'b0; zero_flag = 1'b0;
        compflg_out = 1'b0; control_out = '0; flush = 1'b0; mem_ready = 1'b0;
        trap_exp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_ex_ready",  64'(ex_ready),  64'd1);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_mem_alu",   64'(mem_alu),   64'd0);
        chk("rst_mem_ctrl",  64'(ctrl_bits), 64'd0);
        chk("rst_trap",      64'(trap),      64'd0);
        rst_n = 1'b1;

        // First capture on the edge after reset release
        push(32'hDEAD_BEEF, 32'h0, 3'b000, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Single push then drain
        push(32'h0000_0010, 32'h0000_0100, 3'b010, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Three back-to-back with stall; third refused
        push(32'h11, 32'h200, 3'b001, 1'b0);
        push(32'h22, 32'h204, 3'b011, 1'b0);
        push(32'h33, 32'h208, 3'b000, 1'b0);
        idle(1'b0);
        chk("full_count",    64'(count),    64'd2);
        chk("full_ex_ready", 64'(ex_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill, then flush together with a push of 0x55
        push(32'h44, 32'h300, 3'b000, 1'b0);
        push(32'h45, 32'h304, 3'b000, 1'b0);
        step(1'b1, 32'h55, 32'h0, 32'h308, 3'b000, 8'h55, 1'b1, 1'b1);
        chk("flush_count", 64'(count),     64'd0);
        chk("flush_valid", 64'(mem_valid), 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Simultaneous push and pop at count=1
        push(32'h66, 32'h400, 3'b000, 1'b0);
        push(32'h77, 32'h404, 3'b001, 1'b1);
        chk("pp_count", 64'(count),    64'd1);
        chk("pp_alu",   64'(mem_alu),  64'h77);
        chk("pp_fwd",   64'(fwd_data), 64'h77);
        idle(1'b1);

        // Overflowing bundle
        push(32'h88, 32'h500, 3'b100, 1'b0);
`ifdef EX_MEM_OVERFLOW_TRAP_EN
        chk("ovf_trap",  64'(trap),  64'd1);
        chk("ovf_count", 64'(count), 64'd0);
        idle(1'b1);
        chk("ovf_trap_end", 64'(trap), 64'd0);
`else
        chk("ovf_flags", 64'(mem_flags), 64'b100);
        chk("ovf_count", 64'(count),     64'd1);
        idle(1'b1);
`endif
        idle(1'b1);

        // Random traffic with one mid-run reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst_n = 1'b0;
                #1;
                q.delete();
                trap_exp = 1'b0;
                chk("midrst_count", 64'(count),     64'd0);
                chk("midrst_valid", 64'(mem_valid), 64'd0);
                chk("midrst_trap",  64'(trap),      64'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                 3'($urandom), 8'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0);
        end
        idle(1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage_receiver.md
Name: ex_mem_stage_receiver

Overview:
- Receiving end of the execution-stage output bundle: control_out, alu_data, memory_data, overflow_flag, zero_flag, compflg_out, program_counter.
- Registers the bundle into a 2-entry elastic (skid) buffer with valid/ready flow control.
- Presents the head entry to the memory stage and supports stall and flush.
- Provides a forwarding tap of the newest buffered ALU result for the hazard unit.

Parameters:
- DEPTH, 2, buffer entries; legal values 2 or 4, power of two.
- DATA_W, 32, width of alu_data, memory_data and program_counter.

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX bundle valid this cycle
- ex_ready  out  1  receiver can accept; high when buffer not full
- control_out  in  control_type  EX control word (common package)
- alu_data  in  DATA_W  ALU result
- memory_data  in  DATA_W  store data
- overflow_flag, zero_flag, compflg_out  in  1 each  EX flags
- program_counter  in  DATA_W  PC of instruction
- flush  in  1  squash all buffered and incoming entries
- mem_ready  in  1  memory stage accepts head
- mem_valid  out  1  head entry valid
- mem_ctrl  out  control_type  head control
- mem_alu, mem_wdata, mem_pc  out  DATA_W each  head fields
- mem_flags  out  3  {overflow, zero, comp} of head
- fwd_valid  out  1  forwarding tap valid
- fwd_data  out  DATA_W  alu_data of newest buffered entry
- count  out  $clog2(DEPTH)+1  occupancy
- trap  out  1  overflow trap pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): buffer empty, count=0, mem_valid=0, ex_ready=1, fwd_valid=0, trap=0. All data outputs 0; mem_ctrl = control_type'(0).
- Write: ex_valid && ex_ready, with no flush in the same cycle. The bundle is stored at the write pointer on the rising edge.
- Read: mem_valid && mem_ready. The head is popped on the rising edge.
- mem_* outputs are driven directly from head storage. Latency: push at edge N, visible on mem_* after edge N (one cycle). No combinational path from ex_* to mem_*.
- ex_ready = (count != DEPTH). It depends only on registered state, so it has no combinational dependence on mem_ready.
- Simultaneous push and pop:
  - Count unchanged.
  - Legal when full: ex_ready is 0, so no push occurs.
  - When empty, push with no pop yields count=1.
- Pointers: log2(DEPTH) bits wide and wrap modulo DEPTH. count saturates at neither end, because the handshake rules prevent overflow and underflow.
- flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: count=0, mem_valid=0, fwd_valid=0, and pointers reset to 0.
  - The incoming bundle is discarded.
- Stall: mem_ready=0 holds all mem_* outputs stable until accepted.
- fwd_valid = (count != 0). fwd_data = entry at (wptr-1).
- Flags are stored verbatim and never recomputed.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: EX_MEM_OVERFLOW_TRAP_EN.
- Defined: an accepted bundle with overflow_flag=1 is not stored. trap pulses high for exactly one cycle after the accepting edge, and count is unchanged. flush in the same cycle suppresses both the trap and the store.
- Undefined: the overflow flag passes through in mem_flags[2], and trap is constant 0.

Decomposition:
- common package (existing):
  - control_type.
  - New constants: EXM_DEPTH_DEF=2, FLAG_OVF=2, FLAG_ZERO=1, FLAG_COMP=0.
  - New typedef ex_bundle_t, a packed struct of all EX output fields.
- One natural sub-module, ex_mem_fifo: generic DEPTH-entry FIFO of ex_bundle_t with push, pop, flush and count.
- The top level adds the handshake glue, forwarding tap and trap logic.

Test Plan:
- Reset with ex_valid=1 and alu_data=32'hDEAD_BEEF held -> mem_valid=0, count=0, ex_ready=1. First capture happens on the edge after rst_n deasserts.
- Single push, alu_data=32'h0000_0010, pc=32'h0000_0100, mem_ready=1 -> next cycle mem_valid=1, mem_alu=0x10, mem_pc=0x100. The cycle after, mem_valid=0.
- Back-to-back pushes of 3 entries with mem_ready=0 -> count=2, ex_ready=0 after the second push, third entry not accepted. Raising mem_ready then drains in order.
- Full buffer, then simultaneous flush and push with alu_data=0x55 -> next cycle count=0, mem_valid=0, 0x55 never appears.
- count=1 with simultaneous push and pop -> count stays 1. mem_alu advances to the new entry, and fwd_data equals the newest alu_data.
- With EX_MEM_OVERFLOW_TRAP_EN defined: push with overflow_flag=1 -> trap=1 for one cycle, count unchanged. Without the macro: entry buffered with mem_flags=3'b100.
